// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Holds the fetch-entry bundle passed from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of fetched {pc, instr} entries.
// No overflow protection: the caller only pushes against granted credit.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  // A push into a full FIFO means the credit logic upstream is broken.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && i_push && !w_pop)
      assert (r_count < CW'(DEPTH))
        else $error("fetch_fifo overflow");
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, credit-limited imem requests, response tracking.
// Redirects flush the FIFO and mark in-flight responses for discard.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int            CW  = $clog2(DEPTH + 1);
  localparam logic [CW:0]   LIM = DEPTH[CW:0];

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_exp_pc;
  logic [CW-1:0]   r_pending;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_used;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_req_fire;
  logic            w_keep;
  logic            w_pop;
  logic            w_unused;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused   = ^redirect_pc[1:0];

  assign w_used = {1'b0, r_pending} + {1'b0, w_count};

  assign imem_req_valid = rst_n && !redirect_valid && (w_used < LIM);
  assign imem_addr      = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_keep = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop  = instr_valid && instr_ready;

  assign w_push_data.pc    = r_exp_pc;
  assign w_push_data.instr = imem_rsp_data;

  assign instr    = w_head.instr;
  assign instr_pc = w_head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_exp_pc  <= RESET_PC;
      r_pending <= '0;
      r_drop    <= '0;
    end else begin
      r_pending <= r_pending + CW'(w_req_fire)
                 - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_pc     <= w_redir_pc;
        r_exp_pc <= w_redir_pc;
        // Every outstanding response is stale; this cycle's is eaten here.
        r_drop   <= r_pending - CW'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_pc     <= r_pc + 32'd4;
        if (w_keep)     r_exp_pc <= r_exp_pc + 32'd4;
        if (imem_rsp_valid && (r_drop != '0))
          r_drop <= r_drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_valid (instr_valid),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order latency memory model
// and a request/pop scoreboard driven by redirects and reset.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  int rst_cnt = 0;
  always @(negedge rst_n) rst_cnt++;

  // Memory: in-order, pipelined, fixed latency 'lat' cycles.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  mreq_t mreq;
  int    cyc = 0;
  int    lat = 1;
  int    mem_rst_seen = -1;

  always @(negedge clk) begin
    #4;
    if (rst_cnt != mem_rst_seen || !rst_n) begin
      mem_rst_seen   = rst_cnt;
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (imem_rsp_valid) begin
      void'(mq.pop_front());
    end
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mreq.addr = imem_addr;
      mreq.due  = cyc + lat;
      mq.push_back(mreq);
    end
    if (rst_n) cyc++;
    #2;
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Scoreboard: next expected request address and next expected pop PC.
  logic [31:0] sb_req = '0;
  logic [31:0] sb_pop = '0;
  int          n_req = 0;
  int          n_pop = 0;
  int          sb_rst_seen = -1;

  always @(negedge clk) begin
    #4;
    if (rst_cnt != sb_rst_seen || !rst_n) begin
      sb_rst_seen = rst_cnt;
      sb_req = 32'h0000_0000;
      sb_pop = 32'h0000_0000;
      n_req  = 0;
      n_pop  = 0;
    end
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, sb_req);
        sb_req += 32'd4;
        n_req++;
      end
      if (instr_valid && instr_ready) begin
        chk("pop_pc", instr_pc, sb_pop);
        chk("pop_instr", instr, word_at(sb_pop));
        sb_pop += 32'd4;
        n_pop++;
      end
      if (redirect_valid) begin
        sb_req = {redirect_pc[31:2], 2'b00};
        sb_pop = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid", imem_req_valid, 1);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_instr_valid", instr_valid, 0);

    // Stream: one request per cycle, first instr two cycles later.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stream_addr", imem_addr, 32'(4 * (k + 1)));
      chk("stream_valid", instr_valid, (k >= 1));
      if (k >= 1) chk("stream_pc", instr_pc, 32'(4 * (k - 1)));
    end

    // Backpressure.
    instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_buffered", 32'(n_req - n_pop), 32'd4);
    chk("bp_hold_valid", instr_valid, 1);
    chk("bp_hold_pc", instr_pc, sb_pop);
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_resume", imem_req_valid, 1);
    repeat (8) @(negedge clk);

    // Redirect with a response and a pop in the same cycle.
    chk("t4_pre_rsp", imem_rsp_valid, 1);
    chk("t4_pre_valid", instr_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    #1;
    chk("t4_no_req", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t4_flushed", instr_valid, 0);
    chk("t4_req_valid", imem_req_valid, 1);
    chk("t4_addr", imem_addr, 32'h0000_0300);
    @(negedge clk);
    chk("t4_gap", instr_valid, 0);
    @(negedge clk);
    chk("t4_first_valid", instr_valid, 1);
    chk("t4_first_pc", instr_pc, 32'h0000_0300);
    repeat (3) @(negedge clk);

    // Wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc1", instr_pc, 32'h0000_0000);
    repeat (3) @(negedge clk);

    // Async reset pulse between edges; memory switches to 3 cycles.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_instr_valid", instr_valid, 0);
    lat = 3;
    #1 rst_n = 1'b1;
    #1;
    chk("arst_rel_valid", imem_req_valid, 1);
    chk("arst_rel_addr", imem_addr, 32'h0);

    // Redirect with two requests in flight.
    @(negedge clk);
    @(negedge clk);
    chk("t3_pre_rsp", imem_rsp_valid, 0);
    chk("t3_pre_addr", imem_addr, 32'h0000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    chk("t3_no_req", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("t3_req_valid", imem_req_valid, 1);
    chk("t3_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    chk("t3_first_valid", instr_valid, 1);
    chk("t3_first_pc", instr_pc, 32'h0000_0100);
    repeat (6) @(negedge clk);

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    @(negedge clk);
    redirect_pc    = 32'h0000_0500;
    #1;
    chk("b2b_no_req", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("b2b_addr", imem_addr, 32'h0000_0500);
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    chk("b2b_first_valid", instr_valid, 1);
    chk("b2b_first_pc", instr_pc, 32'h0000_0500);
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
